miriscv_irq_controller: RTL and testbench



---
 rtl/miriscv_pkg.sv | 16 +
 rtl/miriscv_irq_prio_enc.sv | 24 ++
 rtl/miriscv_irq_controller.sv | 84 ++++++++
 tb/tb_miriscv_irq_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// rtl/miriscv_pkg.sv - shared types and constants for the interrupt controller
package miriscv_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [31:0] MCAUSE_IRQ_BIT = 32'h8000_0000;

    function automatic logic [31:0] irq_mcause(input logic [4:0] id);
        return MCAUSE_IRQ_BIT | {27'd0, id};
    endfunction

endpackage

// File: rtl/miriscv_irq_prio_enc.sv
// rtl/miriscv_irq_prio_enc.sv - lowest-index-wins priority encoder
module miriscv_irq_prio_enc
    import miriscv_pkg::*;
#(
    parameter int N_IRQ = 32
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic [4:0]       id_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        id_o    = 5'd0;
        valid_o = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = i[4:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/miriscv_irq_controller.sv
// rtl/miriscv_irq_controller.sv - arbitrates masked level interrupts into one core request
module miriscv_irq_controller
    import miriscv_pkg::*;
#(
    parameter int N_IRQ = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [31:0]      mie_i,
    input  logic             irq_ack_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o
);

    irq_state_e       state_q;
    logic [4:0]       id_q;
    logic             irq_q;
    logic [31:0]      mcause_q;
    logic [N_IRQ-1:0] fin_q;

    logic [N_IRQ-1:0] eligible;
    logic [4:0]       enc_id;
    logic             enc_valid;
    logic             unused_mie;

    assign eligible   = int_req_i & mie_i[N_IRQ-1:0];
    assign unused_mie = ^mie_i;

    miriscv_irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .req_i   (eligible),
        .id_o    (enc_id),
        .valid_o (enc_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IRQ_IDLE;
            id_q     <= 5'd0;
            irq_q    <= 1'b0;
            mcause_q <= 32'h0;
            fin_q    <= '0;
        end else begin
            fin_q <= '0;
            case (state_q)
                IRQ_IDLE: begin
                    // Hold off while the completion pulse is out so the peripheral
                    // gets one cycle to drop its line before re-arbitration.
                    if (enc_valid && (fin_q == '0)) begin
                        id_q     <= enc_id;
                        mcause_q <= irq_mcause(enc_id);
                        irq_q    <= 1'b1;
                        state_q  <= IRQ_REQ;
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack_i) begin
                        irq_q   <= 1'b0;
                        state_q <= IRQ_SERVICE;
                    end
                end
                IRQ_SERVICE: begin
                    if (mret_i) begin
                        fin_q   <= {{(N_IRQ-1){1'b0}}, 1'b1} << id_q;
                        state_q <= IRQ_IDLE;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign irq_o     = irq_q;
    assign mcause_o  = mcause_q;
    assign int_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_irq_controller.sv
// tb/tb_miriscv_irq_controller.sv - directed self-checking bench for miriscv_irq_controller
module tb_miriscv_irq_controller;

    logic        clk;
    logic        reset;
    logic [31:0] int_req_i;
    logic [31:0] mie_i;
    logic        irq_ack_i;
    logic        mret_i;
    logic        irq_o;
    logic [31:0] mcause_o;
    logic [31:0] int_fin_o;

    int nvec;
    int nmis;

    miriscv_irq_controller #(
        .N_IRQ (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .int_req_i (int_req_i),
        .mie_i     (mie_i),
        .irq_ack_i (irq_ack_i),
        .mret_i    (mret_i),
        .irq_o     (irq_o),
        .mcause_o  (mcause_o),
        .int_fin_o (int_fin_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        nvec      = 0;
        nmis      = 0;
        reset     = 1'b1;
        int_req_i = 32'h0;
        mie_i     = 32'hFFFF_FFFF;
        irq_ack_i = 1'b0;
        mret_i    = 1'b0;
        step();
        step();
        check("rst_irq", {31'd0, irq_o}, 32'h0);
        check("rst_mcause", mcause_o, 32'h0);
        check("rst_fin", int_fin_o, 32'h0);
        reset = 1'b0;
        step();

        // single line round trip
        int_req_i = 32'h0000_0010;
        step();
        check("rt_irq", {31'd0, irq_o}, 32'h1);
        check("rt_mcause", mcause_o, 32'h8000_0004);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("rt_ack_irq", {31'd0, irq_o}, 32'h0);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("rt_fin", int_fin_o, 32'h0000_0010);
        int_req_i = 32'h0;
        step();
        check("rt_fin_gone", int_fin_o, 32'h0);
        check("rt_mcause_hold", mcause_o, 32'h8000_0004);
        step();

        // priority with a masked line
        int_req_i = 32'h0000_0A00;
        mie_i     = 32'hFFFF_FDFF;
        step();
        check("pm_irq", {31'd0, irq_o}, 32'h1);
        check("pm_mcause", mcause_o, 32'h8000_000B);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("pm_fin", int_fin_o, 32'h0000_0800);
        int_req_i = 32'h0000_0200;
        step();
        step();
        check("pm_masked_irq", {31'd0, irq_o}, 32'h0);
        int_req_i = 32'h0;
        mie_i     = 32'hFFFF_FFFF;
        step();

        // commitment once latched
        int_req_i = 32'h0000_0008;
        step();
        check("cm_irq", {31'd0, irq_o}, 32'h1);
        int_req_i = 32'h0;
        mie_i     = 32'h0;
        step();
        step();
        check("cm_irq_held", {31'd0, irq_o}, 32'h1);
        check("cm_mcause", mcause_o, 32'h8000_0003);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("cm_ack_irq", {31'd0, irq_o}, 32'h0);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("cm_fin", int_fin_o, 32'h0000_0008);
        mie_i = 32'hFFFF_FFFF;
        step();

        // mret in IDLE is ignored
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("idle_mret_fin", int_fin_o, 32'h0);

        // ack+mret together in REQ, then line 0 arrives during SERVICE of line 5
        int_req_i = 32'h0000_0020;
        step();
        check("am_mcause", mcause_o, 32'h8000_0005);
        irq_ack_i = 1'b1;
        mret_i    = 1'b1;
        step();
        irq_ack_i = 1'b0;
        mret_i    = 1'b0;
        check("am_irq", {31'd0, irq_o}, 32'h0);
        check("am_no_fin", int_fin_o, 32'h0);
        int_req_i = 32'h0000_0021;
        step();
        check("svc_wait_irq", {31'd0, irq_o}, 32'h0);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("am_fin", int_fin_o, 32'h0000_0020);
        int_req_i = 32'h0000_0001;
        step();
        check("gap_irq", {31'd0, irq_o}, 32'h0);
        check("gap_fin", int_fin_o, 32'h0);
        step();
        check("l0_irq", {31'd0, irq_o}, 32'h1);
        check("l0_mcause", mcause_o, 32'h8000_0000);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("l0_fin", int_fin_o, 32'h0000_0001);
        int_req_i = 32'h0;
        step();
        step();

        // persistent request is re-arbitrated two edges after mret
        int_req_i = 32'h0000_0004;
        step();
        check("ps_mcause", mcause_o, 32'h8000_0002);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("ps_fin", int_fin_o, 32'h0000_0004);
        step();
        check("ps_gap_irq", {31'd0, irq_o}, 32'h0);
        step();
        check("ps_re_irq", {31'd0, irq_o}, 32'h1);
        check("ps_re_mcause", mcause_o, 32'h8000_0002);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        int_req_i = 32'h0;

        // asynchronous reset while in SERVICE
        #2 reset = 1'b1;
        #1;
        check("ar_irq", {31'd0, irq_o}, 32'h0);
        check("ar_mcause", mcause_o, 32'h0);
        check("ar_fin", int_fin_o, 32'h0);
        step();
        reset  = 1'b0;
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        check("ar_mret_fin", int_fin_o, 32'h0);
        check("ar_irq_after", {31'd0, irq_o}, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
